// File: rtl/add64_mc_sequencer_if.sv
// Operand request / result handshake bundle for add64_mc_sequencer.
// master = operand source and result consumer, slave = the sequencer.
interface add64_mc_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_a;
  logic [63:0]      in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy, op_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, busy, op_count
  );
endinterface

// File: rtl/add64_mc_sequencer.sv
// Holds operands on a 64-bit carry-select adder for SETTLE_CYCLES cycles, then
// registers sum/carry/overflow and offers them on a valid/ready port.
module CSA_64bit (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic        c_i,
  output logic [63:0] sum_o,
  output logic        c_out_o
);
  logic [32:0] lo;
  logic [32:0] hi0;
  logic [32:0] hi1;
  logic [32:0] hi_sel;

  // Upper half is precomputed for both carry-ins and picked by the lower carry.
  always_comb begin
    lo      = {1'b0, a_i[31:0]} + {1'b0, b_i[31:0]} + {32'b0, c_i};
    hi0     = {1'b0, a_i[63:32]} + {1'b0, b_i[63:32]};
    hi1     = {1'b0, a_i[63:32]} + {1'b0, b_i[63:32]} + 33'd1;
    hi_sel  = lo[32] ? hi1 : hi0;
    sum_o   = {hi_sel[31:0], lo[31:0]};
    c_out_o = hi_sel[32];
  end
endmodule

module add64_mc_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  add64_mc_sequencer_if.slave  bus
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [63:0]      op_a_q, op_a_d;
  logic [63:0]      op_b_q, op_b_d;
  logic             op_cin_q, op_cin_d;
  logic             out_valid_q, out_valid_d;
  logic [63:0]      out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q, out_ovf_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [63:0] add_sum;
  logic        add_cout;

  // Adder sees only registered operands, so its inputs are stable while settling.
  CSA_64bit u_csa (
    .a_i     (op_a_q),
    .b_i     (op_b_q),
    .c_i     (op_cin_q),
    .sum_o   (add_sum),
    .c_out_o (add_cout)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_cin_d    = op_cin_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    op_count_d  = op_count_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          op_a_d   = bus.in_a;
          op_b_d   = bus.in_b;
          op_cin_d = bus.in_cin;
          cnt_d    = 8'(SETTLE_CYCLES - 1);
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == 8'd0) begin
          out_sum_d   = add_sum;
          out_cout_d  = add_cout;
          out_ovf_d   = (op_a_q[63] == op_b_q[63]) && (add_sum[63] != op_a_q[63]);
          out_valid_d = 1'b1;
          state_d     = StHold;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StHold: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          op_count_d  = op_count_q + 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      op_a_q      <= 64'd0;
      op_b_q      <= 64'd0;
      op_cin_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= 64'd0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_cin_q    <= op_cin_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_add64_mc_sequencer.sv
// Bench for add64_mc_sequencer: vector table, backpressure, mid-settle reset and
// counter wrap, with results checked through an expected-result queue.
module tb_add64_mc_sequencer;
  localparam int unsigned S  = 4;
  localparam int unsigned CW = 4;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add64_mc_sequencer_if #(.CNT_W(CW)) bus ();

  add64_mc_sequencer #(
    .SETTLE_CYCLES (S),
    .CNT_W         (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  res_t sb[$];
  vec_t vecs[8];
  int   checks     = 0;
  int   failures   = 0;
  int   cyc        = 0;
  int   accept_cyc = 0;
  int   exp_cnt    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic cin);
    res_t        r;
    logic [64:0] full;
    full   = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    r.sum  = full[63:0];
    r.cout = full[64];
    r.ovf  = (a[63] == b[63]) && (full[63] != a[63]);
    return r;
  endfunction

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic cin,
                       input res_t exp);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("issue_in_ready", {63'd0, bus.in_ready}, 64'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    sb.push_back(exp);
    tick();
    accept_cyc   = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("out_valid_seen", {63'd0, bus.out_valid}, 64'd1);
    chk("latency", 64'(cyc - accept_cyc), 64'(S));
  endtask

  task automatic compare_out();
    res_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk("out_sum", bus.out_sum, e.sum);
      chk("out_cout", {63'd0, bus.out_cout}, {63'd0, e.cout});
      chk("out_ovf", {63'd0, bus.out_ovf}, {63'd0, e.ovf});
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    exp_cnt       = (exp_cnt + 1) % (1 << CW);
    bus.out_ready = 1'b0;
    chk("hs_out_valid_low", {63'd0, bus.out_valid}, 64'd0);
    chk("hs_op_count", 64'(bus.op_count), 64'(exp_cnt));
    chk("hs_in_ready", {63'd0, bus.in_ready}, 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    res_t r;
    r.sum  = v.sum;
    r.cout = v.cout;
    r.ovf  = v.ovf;
    issue(v.a, v.b, v.cin, r);
    for (int i = 1; i <= int'(S); i++) begin
      if (i == 1) begin
        chk("settle_busy", {63'd0, bus.busy}, 64'd1);
        chk("settle_in_ready", {63'd0, bus.in_ready}, 64'd0);
      end
      tick();
      chk("latency_valid", {63'd0, bus.out_valid}, (i == int'(S)) ? 64'd1 : 64'd0);
    end
    compare_out();
    handshake();
  endtask

  task automatic chk_reset_state();
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_sum", bus.out_sum, 64'd0);
    chk("rst_out_cout", {63'd0, bus.out_cout}, 64'd0);
    chk("rst_out_ovf", {63'd0, bus.out_ovf}, 64'd0);
    chk("rst_op_count", 64'(bus.op_count), 64'd0);
  endtask

  initial begin
    vec_t  v;
    res_t  r;
    int    prev_acc;
    logic [63:0] ra, rb;
    logic  rc;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[2] = '{64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[4] = '{64'h3, 64'h4, 1'b0, 64'h7, 1'b0, 1'b0};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[6] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[7] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_state();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Backpressure: result must hold while new requests are ignored.
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, model(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0));
    wait_valid();
    compare_out();
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_a     = 64'h5555_5555_5555_5555 + 64'(i);
      bus.in_b     = 64'h1234;
      bus.in_cin   = 1'b1;
      tick();
      chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("bp_out_sum", bus.out_sum, 64'h8000_0000_0000_0000);
      chk("bp_out_cout", {63'd0, bus.out_cout}, 64'd0);
      chk("bp_out_ovf", {63'd0, bus.out_ovf}, 64'd1);
      chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("bp_op_count", 64'(bus.op_count), 64'(exp_cnt));
    end
    bus.in_valid = 1'b0;
    handshake();
    tick();
    chk("bp_not_queued", {63'd0, bus.busy}, 64'd0);

    // Reset two cycles into SETTLE abandons the operation.
    issue(64'h11, 64'h22, 1'b0, model(64'h11, 64'h22, 1'b0));
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    exp_cnt = 0;
    sb.delete();
    chk_reset_state();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_no_valid", {63'd0, bus.out_valid}, 64'd0);
    end
    v = '{64'h3, 64'h4, 1'b0, 64'h7, 1'b0, 1'b0};
    run_vec(v);

    // Counter wrap and issue interval with out_ready held high.
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    exp_cnt = 0;
    chk("wrap_start", 64'(bus.op_count), 64'd0);
    bus.out_ready = 1'b1;
    prev_acc      = 0;
    for (int n = 0; n < 16; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      r  = model(ra, rb, rc);
      issue(ra, rb, rc, r);
      if (n > 0) chk("issue_interval", 64'(accept_cyc - prev_acc), 64'(S + 2));
      prev_acc = accept_cyc;
      wait_valid();
      compare_out();
      tick();
      exp_cnt = (exp_cnt + 1) % (1 << CW);
      chk("wrap_op_count", 64'(bus.op_count), 64'(exp_cnt));
    end
    bus.out_ready = 1'b0;
    chk("wrap_zero", 64'(bus.op_count), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/add64_mc_sequencer.md
# add64_mc_sequencer

Multi-cycle sequencer that stages operands into the team's 64-bit carry-select adder (CSA_64bit) and captures its result. The adder is modelled with simulated gate delays and is not single-cycle safe. This block holds the operands stable for a programmable number of settle cycles, then registers sum, carry-out and signed overflow. It presents the result on a valid/ready output port. It sits between the operand source (testbench or datapath) and the result consumer, and instantiates one CSA_64bit internally.

## Interface

Parameters:
- SETTLE_CYCLES, default 4: cycles the operands are held before capture; legal range 1..255; 0 is an elaboration error.
- CNT_W, default 16: width of the completed-operation counter.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- in_a  in  64  operand A.
- in_b  in  64  operand B.
- in_cin  in  1  carry-in.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  64  registered sum.
- out_cout  out  1  registered carry-out.
- out_ovf  out  1  registered signed (two's-complement) overflow.
- busy  out  1  high whenever state is not IDLE.
- op_count  out  CNT_W  count of completed output handshakes; wraps modulo 2^CNT_W.

## Operation

- Internal registers: op_a, op_b, op_cin drive the CSA_64bit inputs directly. There is no combinational path from in_* to the adder.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_a/in_b/in_cin into op regs, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - in_ready=0. Counter decrements each cycle.
  - On the edge where the counter equals 0: capture adder sum→out_sum, c_out→out_cout, out_ovf=(op_a[63]==op_b[63])&&(sum[63]!=op_a[63]). Set out_valid=1 and go to HOLD.
- HOLD:
  - in_ready=0. out_valid=1. out_sum, out_cout and out_ovf are held constant.
  - On out_valid&out_ready: out_valid←0, op_count←op_count+1 (wraps), go to IDLE.
- in_valid outside IDLE is ignored; the request is not queued and there is no error flag.
- Operand regs retain their last values after capture. They change only on acceptance or reset.
- Arithmetic: full 64-bit unsigned add with carry-in. out_cout is bit 64. out_ovf uses the signed interpretation of the same sum.

## Timing

- Reset (rst=1 at an edge): state=IDLE, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, op_count=0, op regs=0, counter=0, busy=0. in_ready=1 from the first cycle after reset deasserts.
- Reset mid-SETTLE or mid-HOLD: the operation is abandoned, no result is presented, and op_count is cleared (reset has priority over all other events).
- Latency: operands accepted at edge k → out_valid high after edge k+SETTLE_CYCLES. Example: SETTLE_CYCLES=1 means capture at edge k+1.
- Minimum issue interval: SETTLE_CYCLES+2 cycles (accept, SETTLE_CYCLES settle edges, one handshake edge, back in IDLE).
- out_ready may be high before out_valid. The handshake completes on the first edge where both are high, which is at the earliest edge k+SETTLE_CYCLES+1.
- in_ready and busy are decoded from state only and never depend combinationally on in_valid or out_ready.
- op_count updates on the same edge as the output handshake.

## Test plan

- SETTLE_CYCLES=4, a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0 accepted at edge k → out_valid rises after edge k+4 with out_sum=0, out_cout=1, out_ovf=0.
- a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, cin=0 → out_sum=0x8000_0000_0000_0000, out_cout=0, out_ovf=1.
- a=0x0000_0000_FFFF_FFFF, b=0, cin=1 → out_sum=0x0000_0001_0000_0000, out_cout=0. This exercises the carry across the 32-bit half boundary.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD and pulse in_valid with new operands.
  - out_sum, out_cout and out_valid stay constant; in_ready=0; the new operands are ignored; op_count is unchanged.
  - Raising out_ready then increments op_count by exactly 1.
- Assert rst for one cycle while in SETTLE (2 cycles after acceptance) → all outputs at reset values the next cycle, no out_valid pulse. A following operation 3+4 completes with out_sum=7 after 4 settle cycles.
- CNT_W=4, 16 back-to-back operations with out_ready held at 1 → op_count reads 0 after the 16th handshake. The issue interval measures SETTLE_CYCLES+2 cycles.
